// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
package if_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0028;
  localparam logic [31:0] WORD_BYTES       = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } if_entry_t;

endpackage

// File: rtl/ins_fifo.sv
// DEPTH-entry synchronous FIFO of fetched instructions with flush.
// Head is read straight from storage, so data pushed at edge N shows from N+1.
module ins_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  if_entry_t                push_data,
  input  logic                     pop,
  output if_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Decoupled instruction prefetcher: sequential word fetches, credit-limited
// by DEPTH, buffered with their PC; redirect flushes and drops in-flight data.
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic [31:0] ins_pcp4,
  input  logic        ins_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]  fetch_pc;
  logic [31:0]  rsp_pc;
  logic [31:0]  redir_aligned;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW:0]   inflight;
  logic          grant;
  logic          rsp_ok;
  logic          push;
  logic          pop;
  if_entry_t     head;
  if_entry_t     push_entry;

  assign redir_aligned = redirect_pc & ~32'h3;
  assign inflight      = {1'b0, count} + {1'b0, outstanding};

  // rst_n gates the request so nothing is issued while reset is held
  assign imem_req  = rst_n && !redirect && (inflight < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored
  assign rsp_ok     = imem_rvalid && (outstanding != '0);
  assign push       = rsp_ok && (drop == '0) && !redirect;
  assign push_entry = '{pc: rsp_pc, ins: imem_rdata};

  assign ins_valid = (count != '0) && !redirect;
  assign pop       = ins_valid && ins_ready;
  assign ins       = head.ins;
  assign ins_pc    = head.pc;
  assign ins_pcp4  = head.pc + WORD_BYTES;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect) begin
      // Every request not yet answered becomes stale and must be dropped
      fetch_pc    <= redir_aligned;
      rsp_pc      <= redir_aligned;
      outstanding <= outstanding - CW'(rsp_ok);
      drop        <= outstanding - CW'(rsp_ok);
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + WORD_BYTES;
      end
      outstanding <= outstanding + CW'(grant) - CW'(rsp_ok);
      if (rsp_ok) begin
        if (drop != '0) begin
          drop <= drop - CW'(1);
        end else begin
          rsp_pc <= rsp_pc + WORD_BYTES;
        end
      end
    end
  end

  ins_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: behavioural memory, scoreboard of
// expected {pc, ins} per accepted instruction, plus direct timing checks.
module tb_if_prefetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic [31:0] ins_pcp4;
  logic        ins_ready;

  always #5 clk = ~clk;

  if_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h28)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ins_valid   (ins_valid),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .ins_pcp4    (ins_pcp4),
    .ins_ready   (ins_ready)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h28:  return 32'h00500093;
      32'h2C:  return 32'h00A00113;
      32'h30:  return 32'h002081B3;
      default: return a ^ 32'hC0DE0013;
    endcase
  endfunction

  // Memory model: in-order responses, fixed latency per phase
  typedef struct { logic [31:0] addr; int unsigned due; } pend_t;
  pend_t       pend[$];
  int unsigned cyc    = 0;
  int unsigned lat    = 1;
  int unsigned grants = 0;
  bit          gnt_en = 1'b1;

  assign imem_gnt = gnt_en;

  initial begin : memory
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin : mem_cycle
      bit          g;
      logic [31:0] a;
      @(negedge clk);
      g = imem_req && imem_gnt;
      a = imem_addr;
      @(posedge clk);
      if (g) begin
        pend.push_back('{a, cyc + lat});
        grants++;
      end
      cyc++;
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end
    end
  end

  // Scoreboard
  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
  exp_t        exp_q[$];
  int unsigned pops = 0;

  task automatic expect_seq(input logic [31:0] start, input int unsigned n);
    logic [31:0] pc;
    pc = start;
    for (int unsigned i = 0; i < n; i++) begin
      exp_q.push_back('{pc, mem_word(pc)});
      pc = pc + 32'd4;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && ins_valid === 1'b1 && ins_ready === 1'b1) begin
      pops++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pop_unexpected: got pc %h expected no instruction", ins_pc);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc",   ins_pc,   e.pc);
        check("pop_pcp4", ins_pcp4, e.pc + 32'd4);
        check("pop_ins",  ins,      e.ins);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pops(input int unsigned n, input string name);
    int unsigned k;
    k = 0;
    while (pops < n && k < 50) begin
      tick();
      k++;
    end
    check(name, 32'(pops >= n), 32'd1);
  endtask

  task automatic enter_reset(input int unsigned new_lat, input logic ready);
    rst_n = 1'b0;
    pend.delete();
    exp_q.delete();
    lat       = new_lat;
    ins_ready = ready;
    gnt_en    = 1'b1;
    tick();
    pops = 0;
  endtask

  initial begin : stimulus
    int unsigned c0;
    int unsigned cv;
    int unsigned g0;
    int unsigned k;

    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    ins_ready   = 1'b1;
    repeat (2) tick();

    check("rst_ins_valid", 32'(ins_valid), 32'd0);
    check("rst_ins",       ins,            32'd0);
    check("rst_ins_pc",    ins_pc,         32'd0);
    check("rst_ins_pcp4",  ins_pcp4,       32'd4);
    check("rst_imem_req",  32'(imem_req),  32'd0);

    // Release, 1-cycle memory, ready high
    expect_seq(32'h28, 64);
    pops  = 0;
    rst_n = 1'b1;
    #1;
    check("release_req",  32'(imem_req), 32'd1);
    check("release_addr", imem_addr,     32'h28);
    c0 = cyc;
    cv = c0 + 100;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ins_valid) begin
        cv = cyc;
        break;
      end
    end
    check("first_valid_latency", cv - c0, 32'd2);
    tick();
    repeat (2) tick();
    check("throughput_pops", pops, 32'd3);

    // Stalled decode: credit limit holds exactly DEPTH entries
    enter_reset(1, 1'b0);
    expect_seq(32'h28, 64);
    g0    = grants;
    rst_n = 1'b1;
    repeat (10) tick();
    check("stall_grants",  grants - g0,     32'd4);
    check("stall_req_low", 32'(imem_req),   32'd0);
    check("stall_valid",   32'(ins_valid),  32'd1);
    check("stall_head_pc", ins_pc,          32'h28);
    check("stall_no_pops", pops,            32'd0);
    ins_ready = 1'b1;
    repeat (4) tick();
    check("drain_pops", pops, 32'd4);

    // Latency 3, redirect with three requests outstanding
    enter_reset(3, 1'b1);
    g0    = grants;
    rst_n = 1'b1;
    k = 0;
    while (grants - g0 < 3 && k < 10) begin
      tick();
      k++;
    end
    check("c_three_outstanding", grants - g0, 32'd3);
    exp_q.delete();
    expect_seq(32'h100, 64);
    pops        = 0;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    #1;
    check("redir_req_low",   32'(imem_req),  32'd0);
    check("redir_valid_low", 32'(ins_valid), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("redir_next_req",  32'(imem_req), 32'd1);
    check("redir_next_addr", imem_addr,     32'h100);
    wait_pops(3, "redir_pops");

    // Redirect coinciding with a response and a pop
    enter_reset(1, 1'b1);
    expect_seq(32'h28, 64);
    rst_n = 1'b1;
    repeat (6) tick();
    check("d_rsp_and_pop", {30'd0, imem_rvalid, ins_valid}, 32'd3);
    exp_q.delete();
    expect_seq(32'h200, 64);
    pops        = 0;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    #1;
    check("d_valid_masked", 32'(ins_valid), 32'd0);
    tick();
    redirect = 1'b0;
    wait_pops(3, "d_pops");

    // Misaligned redirect near the top of the address space
    exp_q.delete();
    expect_seq(32'hFFFF_FFFC, 64);
    pops        = 0;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    #1;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr1", imem_addr, 32'h0000_0000);
    wait_pops(2, "wrap_pops");

    // Reset pulse while data is buffered and requests are outstanding
    enter_reset(3, 1'b0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("f_setup_valid", 32'(ins_valid), 32'd1);
    gnt_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("f_rst_valid", 32'(ins_valid), 32'd0);
    check("f_rst_req",   32'(imem_req),  32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("f_restart_req",  32'(imem_req), 32'd1);
    check("f_restart_addr", imem_addr,     32'h28);
    k = 0;
    while ((pend.size() > 0 || imem_rvalid) && k < 10) begin
      tick();
      k++;
    end
    tick();
    check("f_late_ignored", 32'(ins_valid), 32'd0);
    expect_seq(32'h28, 64);
    pops      = 0;
    ins_ready = 1'b1;
    gnt_en    = 1'b1;
    wait_pops(3, "f_pops");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
